// File: rtl/ahb_ram_subordinate.sv
// AHB-Lite responder in front of a single-port word RAM with wait states.
// Optional AHB_RAM_ERR_EN: ERROR response on bad size/alignment/range.
module ahb_ram_subordinate #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic [31:0] hrdata,
   output logic        hreadyout,
   output logic        hresp
);

   typedef enum logic [1:0] {
      H_IDLE   = 2'b00,
      H_BUSY   = 2'b01,
      H_NONSEQ = 2'b10,
      H_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_DONE = 3'd2,
      S_ERR1 = 3'd3,
      S_ERR2 = 3'd4
   } state_t;

   localparam logic [2:0] WS_LOAD =
      3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        size_q, size_d;
   logic              wr_q, wr_d;
   logic [31:0]       hrdata_q, hrdata_d;

   htrans_t           trans;
   logic [ADDR_W-1:0] acc_idx;
   logic              addr_err;
   logic              acc;
   logic              rd_acc;
   logic              commit;
   logic              fwd;
   logic [3:0]        strb;
   logic              unused_in;

   assign trans   = htrans_t'(htrans);
   assign acc_idx = haddr[ADDR_W+1:2];

`ifdef AHB_RAM_ERR_EN
   assign addr_err = (hsize > 3'd2)
                   | ((hsize == 3'd1) & haddr[0])
                   | ((hsize == 3'd2) & (|haddr[1:0]))
                   | (|haddr[31:ADDR_W+2]);
   assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign unused_in = ^hburst;
`else
   assign addr_err  = 1'b0;
   assign hresp     = 1'b0;
   assign unused_in = ^{hburst, haddr[31:ADDR_W+2]};
`endif

   assign hreadyout = !((state_q == S_WAIT) || (state_q == S_ERR1));
   assign acc    = hreadyout & hsel & hready
                 & ((trans == H_NONSEQ) || (trans == H_SEQ));
   assign rd_acc = acc & ~hwrite & ~addr_err;
   assign commit = (state_q == S_DONE) & wr_q;
   assign fwd    = commit & (acc_idx == idx_q);

   // Next state: count down wait states, capture a new address phase.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      off_d   = off_q;
      size_d  = size_q;
      wr_d    = wr_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q == 3'd0) state_d = S_DONE;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
      if (acc) begin
         idx_d  = acc_idx;
         off_d  = haddr[1:0];
         size_d = hsize;
         wr_d   = hwrite & ~addr_err;
         if (addr_err) begin
            state_d = S_ERR1;
         end else if (WAIT_STATES == 0) begin
            state_d = S_DONE;
         end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
         end
      end
   end

   // Little-endian lane strobes; misaligned offsets fold to lane pairs.
   always_comb begin
      strb = 4'b1111;
      unique case (1'b1)
         size_q == 3'd0: strb = 4'b0001 << off_q;
         size_q == 3'd1: strb = off_q[1] ? 4'b1100 : 4'b0011;
         default:        strb = 4'b1111;
      endcase
   end

   // Read word at accept, merging lanes of a write committing this edge.
   always_comb begin
      hrdata_d = hrdata_q;
      if (rd_acc) begin
         for (int i = 0; i < 4; i++) begin
            hrdata_d[8*i+:8] = (fwd & strb[i]) ? hwdata[8*i+:8]
                                               : mem[acc_idx][8*i+:8];
         end
      end
   end

   // Control and read-data registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 3'd0;
         idx_q    <= '0;
         off_q    <= 2'd0;
         size_q   <= 3'd0;
         wr_q     <= 1'b0;
         hrdata_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         off_q    <= off_d;
         size_q   <= size_d;
         wr_q     <= wr_d;
         hrdata_q <= hrdata_d;
      end
   end

   // RAM array: strobed write at the end of the final data-phase cycle.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (strb[i]) mem[idx_q][8*i+:8] <= hwdata[8*i+:8];
         end
      end
   end

   assign hrdata = hrdata_q;

endmodule

// File: tb/tb_ahb_ram_subordinate.sv
// Bench for ahb_ram_subordinate: one zero-wait and one two-wait instance,
// pipelined AHB master with a memory model and expected-read queue.
module tb_ahb_ram_subordinate;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        h0;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic        clk;
   logic        nrst;
   logic        hsel      [2];
   logic [31:0] haddr     [2];
   logic [1:0]  htrans    [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic [2:0]  hburst    [2];
   logic [31:0] hwdata    [2];
   logic        hready    [2];
   logic        hr0       [2];
   logic [31:0] hrdata    [2];
   logic        hreadyout [2];
   logic        hresp     [2];

   int          n_chk;
   int          n_pass;
   req_t        rq [$];
   logic [31:0] expq [$];
   logic [31:0] mdl [int];
   logic [31:0] last_rd [2];
   int          first_done;
   int          last_done;

   assign hready[0] = hreadyout[0] & ~hr0[0];
   assign hready[1] = hreadyout[1] & ~hr0[1];

   ahb_ram_subordinate #(.ADDR_W(12), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .nrst(nrst), .hsel(hsel[0]), .haddr(haddr[0]),
      .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]),
      .hburst(hburst[0]), .hwdata(hwdata[0]), .hready(hready[0]),
      .hrdata(hrdata[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0])
   );

   ahb_ram_subordinate #(.ADDR_W(12), .WAIT_STATES(2)) u_dut2 (
      .clk(clk), .nrst(nrst), .hsel(hsel[1]), .haddr(haddr[1]),
      .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]),
      .hburst(hburst[1]), .hwdata(hwdata[1]), .hready(hready[1]),
      .hrdata(hrdata[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
   endtask

   function automatic int key(int d, logic [31:0] a);
      return d * 65536 + int'(a[13:2]);
   endfunction

   function automatic logic [31:0] mdl_rd(int d, logic [31:0] a);
      return mdl.exists(key(d, a)) ? mdl[key(d, a)] : 32'h0;
   endfunction

   task automatic mdl_wr(int d, logic [31:0] a, logic [2:0] sz,
                         logic [31:0] wd);
      logic [31:0] w;
      logic [3:0]  ln;
      w = mdl_rd(d, a);
      case (sz)
         3'd0:    ln = 4'b0001 << a[1:0];
         3'd1:    ln = a[1] ? 4'b1100 : 4'b0011;
         default: ln = 4'b1111;
      endcase
      for (int i = 0; i < 4; i++)
         if (ln[i]) w[8*i+:8] = wd[8*i+:8];
      mdl[key(d, a)] = w;
   endtask

   function automatic req_t mk(logic sel, logic [1:0] tr, logic h0,
                               logic wr, logic [2:0] sz,
                               logic [31:0] a, logic [31:0] wd);
      req_t r;
      r.sel = sel; r.trans = tr; r.h0 = h0; r.wr = wr;
      r.size = sz; r.addr = a; r.wdata = wd;
      return r;
   endfunction

   function automatic bit is_xfer(req_t r);
      return r.sel & r.trans[1] & ~r.h0;
   endfunction

   task automatic q_wr(logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
      rq.push_back(mk(1'b1, 2'b10, 1'b0, 1'b1, sz, a, wd));
   endtask

   task automatic q_rd(logic [31:0] a, logic [1:0] tr);
      rq.push_back(mk(1'b1, tr, 1'b0, 1'b0, 3'd2, a, 32'h0));
   endtask

   task automatic drv_idle(int d);
      hsel[d]   = 1'b0;
      haddr[d]  = 32'h0;
      htrans[d] = 2'b00;
      hwrite[d] = 1'b0;
      hsize[d]  = 3'd2;
      hr0[d]    = 1'b0;
   endtask

   // Drive the request queue through bus d, checking each completion.
   task automatic run(int d, int ws);
      req_t        a, p;
      bit          av, pv;
      int          low, cyc;
      logic        rdy;
      logic [31:0] e;
      av = 0; pv = 0; low = 0; cyc = 0;
      first_done = -1; last_done = -1;
      while (rq.size() > 0 || av || pv) begin
         if (!av && rq.size() > 0) begin
            a = rq.pop_front();
            av = 1;
            hsel[d]   = a.sel;
            haddr[d]  = a.addr;
            htrans[d] = a.trans;
            hwrite[d] = a.wr;
            hsize[d]  = a.size;
            hr0[d]    = a.h0;
            if (is_xfer(a)) begin
               if (a.wr) mdl_wr(d, a.addr, a.size, a.wdata);
               else begin
                  e = mdl_rd(d, a.addr);
                  expq.push_back(e);
                  last_rd[d] = e;
               end
            end
         end else if (!av) begin
            drv_idle(d);
         end
         hwdata[d] = pv ? p.wdata : 32'h0;
         @(negedge clk);
         rdy = hreadyout[d];
         chk("hresp_okay", {31'd0, hresp[d]}, 32'd0);
         if (pv) begin
            if (!rdy) low++;
            else begin
               chk("wait_cycles", low, ws);
               if (!p.wr) chk("hrdata", hrdata[d], expq.pop_front());
               if (first_done < 0) first_done = cyc;
               last_done = cyc;
               pv = 0;
            end
         end else if (av && !is_xfer(a)) begin
            chk("idle_ready", {31'd0, rdy}, 32'd1);
            chk("idle_hrdata", hrdata[d], last_rd[d]);
         end
         @(posedge clk);
         #1;
         cyc++;
         if (rdy && av) begin
            if (is_xfer(a)) begin
               p = a;
               pv = 1;
               low = 0;
            end
            av = 0;
         end
         if (cyc > 400) begin
            chk("run_timeout", cyc, 400);
            rq.delete();
            expq.delete();
            drv_idle(d);
            return;
         end
      end
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      nrst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         drv_idle(d);
         hburst[d]  = 3'd0;
         hwdata[d]  = 32'h0;
         last_rd[d] = 32'h0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", {31'd0, hreadyout[d]}, 32'd1);
         chk("rst_hresp", {31'd0, hresp[d]}, 32'd0);
         chk("rst_hrdata", hrdata[d], 32'd0);
      end
      nrst = 1'b1;
      @(posedge clk);
      #1;

      // Two wait states: word write then back-to-back read.
      q_wr(32'h40, 3'd2, 32'h12345678);
      q_rd(32'h40, 2'b10);
      run(1, 2);

      // Byte and halfword lanes over a word, then read back.
      q_wr(32'h40, 3'd2, 32'h11223344);
      q_wr(32'h41, 3'd0, 32'h0000AA00);
      q_wr(32'h42, 3'd1, 32'hBBCC0000);
      q_rd(32'h40, 2'b10);
      q_wr(32'h84, 3'd1, 32'h00005566);
      q_wr(32'h87, 3'd0, 32'h77000000);
      q_rd(32'h84, 2'b10);
      run(1, 2);

      // Reset during a wait state drops the pending write.
      q_wr(32'h10, 3'd2, 32'h11111111);
      q_rd(32'h10, 2'b10);
      run(1, 2);
      hsel[1]   = 1'b1;
      haddr[1]  = 32'h10;
      htrans[1] = 2'b10;
      hwrite[1] = 1'b1;
      hsize[1]  = 3'd2;
      @(posedge clk);
      #1;
      drv_idle(1);
      hwdata[1] = 32'hDEADBEEF;
      @(negedge clk);
      chk("wait_before_rst", {31'd0, hreadyout[1]}, 32'd0);
      #2;
      nrst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_ready", {31'd0, hreadyout[1]}, 32'd1);
      chk("midrst_hresp", {31'd0, hresp[1]}, 32'd0);
      chk("midrst_hrdata", hrdata[1], 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      @(posedge clk);
      #1;
      q_rd(32'h10, 2'b10);
      run(1, 2);

      // Zero wait states: write forwarded to an immediate read.
      q_wr(32'h100, 3'd2, 32'hCAFEF00D);
      q_rd(32'h100, 2'b10);
      run(0, 0);

      // Non-transfers: IDLE, BUSY, deselected, and hready low.
      rq.push_back(mk(1'b1, 2'b00, 1'b0, 1'b1, 3'd2, 32'h100, 32'hFFFFFFFF));
      rq.push_back(mk(1'b0, 2'b10, 1'b0, 1'b1, 3'd2, 32'h100, 32'hFFFFFFFF));
      rq.push_back(mk(1'b1, 2'b01, 1'b0, 1'b1, 3'd2, 32'h100, 32'hFFFFFFFF));
      rq.push_back(mk(1'b1, 2'b10, 1'b1, 1'b1, 3'd2, 32'h100, 32'hFFFFFFFF));
      rq.push_back(mk(1'b1, 2'b10, 1'b1, 1'b0, 3'd2, 32'h200, 32'h0));
      run(0, 0);
      q_rd(32'h100, 2'b10);
      run(0, 0);

      // Eight pipelined reads at one transfer per cycle.
      for (int i = 0; i < 8; i++)
         q_wr(32'h200 + 32'(4 * i), 3'd2, 32'h10000000 + 32'(i * 32'h01010101));
      run(0, 0);
      for (int i = 0; i < 8; i++)
         q_rd(32'h200 + 32'(4 * i), (i == 0) ? 2'b10 : 2'b11);
      run(0, 0);
      chk("throughput", last_done - first_done + 1, 8);

      // Partial forwarding: byte write then same-word read.
      q_wr(32'h300, 3'd2, 32'h01020304);
      q_wr(32'h302, 3'd0, 32'h00550000);
      q_rd(32'h300, 2'b10);
`ifndef AHB_RAM_ERR_EN
      q_wr(32'h303, 3'd1, 32'h77660000);
      q_rd(32'h300, 2'b10);
      q_wr(32'h00010304, 3'd2, 32'hA5A5A5A5);
      q_rd(32'h304, 2'b10);
`endif
      run(0, 0);

`ifdef AHB_RAM_ERR_EN
      // Misaligned word read answered with two-cycle ERROR.
      q_wr(32'h0, 3'd2, 32'h5A5A0001);
      q_rd(32'h0, 2'b10);
      run(0, 0);
      hsel[0]   = 1'b1;
      haddr[0]  = 32'h2;
      htrans[0] = 2'b10;
      hwrite[0] = 1'b0;
      hsize[0]  = 3'd2;
      @(posedge clk);
      #1;
      drv_idle(0);
      @(negedge clk);
      chk("err1_hresp", {31'd0, hresp[0]}, 32'd1);
      chk("err1_ready", {31'd0, hreadyout[0]}, 32'd0);
      @(negedge clk);
      chk("err2_hresp", {31'd0, hresp[0]}, 32'd1);
      chk("err2_ready", {31'd0, hreadyout[0]}, 32'd1);
      @(negedge clk);
      chk("err_after_hresp", {31'd0, hresp[0]}, 32'd0);
      chk("err_hrdata", hrdata[0], last_rd[0]);
      @(posedge clk);
      #1;
      q_rd(32'h0, 2'b10);
      run(0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
